keymem_arbiter: RTL and testbench
=================================

# keymem_arbiter

Shares a single keymem key-lookup port between NUM_REQ network-path instances in the clk156 domain. Each network path issues a level-held key request (key_req/key_id); the arbiter grants one requester at a time in round-robin order, forwards the key ID to the keymem, and returns the 256-bit key with a one-cycle acknowledge. A keymem response that does not arrive within TIMEOUT_CYCLES is reported to the requester as an error.

## Interface
- NUM_REQ, 4: number of network-path requesters; legal range 1..8.
- TIMEOUT_CYCLES, 1024: maximum cycles km_key_req stays high before an error is reported; legal range 1..65535.

- clk156  in  1  key clock, 156.25 MHz.
- areset_clk156  in  1  reset, asynchronous, active-high.
- req_key_req  in  NUM_REQ  per-requester request level.
- req_key_id  in  NUM_REQ*32  per-requester key ID. Requester i uses bits [i*32 +: 32].
- req_key_ack  out  NUM_REQ  one-cycle key-valid pulse to the granted requester.
- req_key_error  out  NUM_REQ  one-cycle timeout pulse to the granted requester.
- req_key  out  256  registered key, broadcast to all requesters.
- km_key_req  out  1  request level to the keymem.
- km_key_id  out  32  key ID to the keymem.
- km_key_ack  in  1  keymem acknowledge; km_key is valid in the same cycle.
- km_key  in  256  key from the keymem.
- busy  out  1  high in every state except IDLE.
- timeout_count  out  16  saturating count of timeouts.

## Operation
- Requester protocol:
  - Requester raises req_key_req[i] and holds req_key_id[i] stable.
  - It keeps req_key_req[i] high until it sees req_key_ack[i] or req_key_error[i], then drops it.
- Keymem protocol: km_key_req is held high with km_key_id stable until km_key_ack.
- FSM states and transitions:
  - IDLE:
    - If any req_key_req bit is set, select a requester round-robin, starting the search at last_grant+1 mod NUM_REQ.
    - Register grant and last_grant <= grant.
    - Latch km_key_id <= req_key_id[grant] and clear the timer. Go to REQ.
  - REQ:
    - km_key_req=1 and the timer increments every cycle.
    - If km_key_ack, capture req_key <= km_key and go to RESP.
    - Otherwise, if the timer equals TIMEOUT_CYCLES-1, go to ERR.
  - RESP: req_key_ack[grant]=1 for exactly one cycle, then go to DROP.
  - ERR: req_key_error[grant]=1 for exactly one cycle; timeout_count increments and saturates at 0xFFFF. Go to DROP.
  - DROP: wait until req_key_req[grant]==0, then go to IDLE.
- Reset sets last_grant=NUM_REQ-1, so requester 0 has priority after reset.
- req_key holds its last captured value until the next km_key_ack. It is not cleared on error.
- Boundary conditions:
  - km_key_ack and timeout in the same cycle: the ack wins and the FSM goes to RESP.
  - km_key_ack outside REQ (for example, a late response after a timeout): ignored. req_key is unchanged.
  - Requester drops its request during REQ: the transaction completes normally and the ack or error is still pulsed. DROP exits on its first cycle.
  - Requests from non-granted requesters are held off. They are never lost, as long as the requester holds its level.
  - NUM_REQ=1: the arbiter degenerates to a pass-through with a timeout.
  - Reset asserted mid-transaction: all state and outputs return to reset values asynchronously. The in-flight keymem request is abandoned.

## Timing
- Reset value of every output is 0.
- All outputs are registered.
- Request latency:
  - Request asserted at cycle 0 (FSM in IDLE): km_key_req and km_key_id are valid from cycle 1.
  - km_key_ack at cycle k: req_key is valid and req_key_ack pulses at cycle k+1.
  - Minimum request-to-ack latency is 2 cycles.
- Timeout: with no ack, km_key_req is high for exactly TIMEOUT_CYCLES cycles, cycles 1..TIMEOUT_CYCLES. req_key_error pulses at cycle TIMEOUT_CYCLES+1.
- Turnaround: IDLE is re-entered one cycle after the granted requester's req_key_req is sampled low in DROP. The next grant is registered on the following edge.
- Throughput for back-to-back requesters, with a 1-cycle keymem and requesters that drop immediately: one key every 5 cycles.

## Test plan
- Single request, keymem ack after 3 cycles:
  - Stimulus: req_key_req[2]=1, req_key_id[2]=0x0000_00A5 at cycle 0; keymem acks at cycle 3 with km_key=256'h1234….
  - Response: km_key_id=0xA5 at cycle 1; req_key_ack[2] pulses at cycle 4 with req_key=256'h1234…; no other ack or error bits.
- Round-robin fairness:
  - Stimulus: all four requesters held high after reset; 1-cycle keymem; each requester drops on ack and re-raises 2 cycles later.
  - Response: grant order 0,1,2,3,0,1,…; no requester starved over 40 grants.
- Timeout with TIMEOUT_CYCLES=8:
  - Stimulus: keymem never acks.
  - Response: km_key_req high for 8 cycles; req_key_error[grant] pulses once; timeout_count=1; req_key unchanged.
  - Stimulus: a late km_key_ack 5 cycles later.
  - Response: ignored.
- Ack and timeout coincide:
  - Stimulus: km_key_ack asserted on the 8th REQ cycle.
  - Response: req_key_ack pulses; no error; timeout_count unchanged.
- Requester abort and reset mid-operation:
  - Stimulus: requester 1 drops req_key_req during REQ.
  - Response: req_key_ack[1] still pulses and the FSM returns to IDLE with no DROP stall.
  - Stimulus: areset_clk156 pulsed during a later REQ.
  - Response: all outputs 0 immediately; the next grant after reset goes to requester 0.
- Saturation:
  - Stimulus: force 65537 timeouts (TIMEOUT_CYCLES=1).
  - Response: timeout_count stays at 0xFFFF.

Source files
------------

// File: rtl/keymem_arbiter.sv
// keymem_arbiter: round-robin arbiter that shares one keymem key-lookup port
// between NUM_REQ requesters in the clk156 domain. Each transaction is guarded
// by a timeout that reports an error to the requester and counts the event.
module keymem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk156,
    input  logic                   areset_clk156,
    input  logic [NUM_REQ-1:0]     req_key_req,
    input  logic [NUM_REQ*32-1:0]  req_key_id,
    output logic [NUM_REQ-1:0]     req_key_ack,
    output logic [NUM_REQ-1:0]     req_key_error,
    output logic [255:0]           req_key,
    output logic                   km_key_req,
    output logic [31:0]            km_key_id,
    input  logic                   km_key_ack,
    input  logic [255:0]           km_key,
    output logic                   busy,
    output logic [15:0]            timeout_count
);

    localparam int              GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GW-1:0]   LAST_INIT  = GW'(NUM_REQ - 1);
    localparam logic [15:0]     TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        ERR  = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       pick;
    logic                pick_valid;
    logic [31:0]         pick_id;
    logic                grant_req;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [15:0]         timer;
    logic                start_req;
    logic                take_key;
    logic                take_err;

    // Round-robin search: first requesting index starting at last_grant+1.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pick_valid && req_key_req[j] &&
                    (j == (int'(last_grant) + 1 + k) % NUM_REQ)) begin
                    pick_valid = 1'b1;
                    pick       = GW'(j);
                    pick_id    = req_key_id[j*32 +: 32];
                end
            end
        end
    end

    // Decode the registered grant into its request level and a one-hot mask.
    always_comb begin
        grant_req    = 1'b0;
        grant_onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (GW'(j) == grant) begin
                grant_req       = req_key_req[j];
                grant_onehot[j] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk156 or posedge areset_clk156) begin
        if (areset_clk156) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an ack in the last timer cycle takes precedence over the timeout.
    always_comb begin
        state_next = state;
        start_req  = 1'b0;
        take_key   = 1'b0;
        take_err   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    start_req  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (km_key_ack) begin
                    take_key   = 1'b1;
                    state_next = RESP;
                end else if (timer == TIMER_LAST) begin
                    take_err   = 1'b1;
                    state_next = ERR;
                end
            end
            RESP: state_next = DROP;
            ERR:  state_next = DROP;
            DROP: begin
                if (!grant_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and transaction bookkeeping; pulses are set on the
    // transition edge so they appear during the RESP/ERR cycle.
    always_ff @(posedge clk156 or posedge areset_clk156) begin
        if (areset_clk156) begin
            grant         <= '0;
            last_grant    <= LAST_INIT;
            km_key_req    <= 1'b0;
            km_key_id     <= '0;
            timer         <= '0;
            req_key       <= '0;
            req_key_ack   <= '0;
            req_key_error <= '0;
            timeout_count <= '0;
            busy          <= 1'b0;
        end else begin
            req_key_ack   <= take_key ? grant_onehot : '0;
            req_key_error <= take_err ? grant_onehot : '0;
            busy          <= (state_next != IDLE);
            if (start_req) begin
                grant      <= pick;
                last_grant <= pick;
                km_key_id  <= pick_id;
                km_key_req <= 1'b1;
                timer      <= '0;
            end else if (state == REQ) begin
                timer <= timer + 16'd1;
                if (take_key || take_err) begin
                    km_key_req <= 1'b0;
                end
            end
            if (take_key) begin
                req_key <= km_key;
            end
            if (take_err && (timeout_count != 16'hFFFF)) begin
                timeout_count <= timeout_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_keymem_arbiter.sv
// Testbench for keymem_arbiter: table of single transactions plus hand-written
// sequences for timeout, late ack, abort, reset, fairness and saturation.
module tb_keymem_arbiter;

    localparam int NR = 4;
    localparam int TO = 8;
    localparam logic [255:0] LATE_KEY = {8{32'hBAD0_BAD0}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_key_req;
    logic [NR*32-1:0]  req_key_id;
    logic [NR-1:0]     req_key_ack;
    logic [NR-1:0]     req_key_error;
    logic [255:0]      req_key;
    logic              km_key_req;
    logic [31:0]       km_key_id;
    logic              km_key_ack;
    logic [255:0]      km_key;
    logic              busy;
    logic [15:0]       timeout_count;

    logic [0:0]        req1;
    logic [31:0]       id1;
    logic [0:0]        ack1;
    logic [0:0]        err1;
    logic [255:0]      key1;
    logic              kmreq1;
    logic [31:0]       kmid1;
    logic              kmack1;
    logic [255:0]      kmkey1;
    logic              busy1;
    logic [15:0]       tc1;

    keymem_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk156(clk), .areset_clk156(rst),
        .req_key_req(req_key_req), .req_key_id(req_key_id),
        .req_key_ack(req_key_ack), .req_key_error(req_key_error),
        .req_key(req_key), .km_key_req(km_key_req), .km_key_id(km_key_id),
        .km_key_ack(km_key_ack), .km_key(km_key),
        .busy(busy), .timeout_count(timeout_count)
    );

    keymem_arbiter #(.NUM_REQ(1), .TIMEOUT_CYCLES(1)) dut1 (
        .clk156(clk), .areset_clk156(rst),
        .req_key_req(req1), .req_key_id(id1),
        .req_key_ack(ack1), .req_key_error(err1),
        .req_key(key1), .km_key_req(kmreq1), .km_key_id(kmid1),
        .km_key_ack(kmack1), .km_key(kmkey1),
        .busy(busy1), .timeout_count(tc1)
    );

    typedef struct { int who; bit err; logic [255:0] key; } exp_t;
    typedef struct { logic [3:0] mask; int lat; int grant; bit err; } vec_t;

    exp_t         sb_q[$];
    vec_t         vt[9];
    int           n_vec = 0;
    int           n_bad = 0;
    int           sb_pops = 0;
    int           cyc = 0;
    int           late_cyc = -1;
    int           km_lat = 0;
    int           mdl_tc = 0;
    logic [255:0] mdl_key = '0;
    logic [NR-1:0] seen_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] key_of(input logic [31:0] id);
        return {32'h1234_5678 ^ id, ~id, id + 32'd1, id ^ 32'h5A5A_0F0F, {4{id}}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    // Keymem model: acks on the km_lat-th cycle of a request (0 = never), or at late_cyc.
    initial begin : keymem_model
        int km_n;
        km_n = 0;
        km_key_ack = 1'b0;
        km_key = '0;
        forever begin
            @(posedge clk); #1;
            km_key_ack = 1'b0;
            if (km_key_req) km_n++; else km_n = 0;
            if (km_key_req && km_lat != 0 && km_n == km_lat) begin
                km_key_ack = 1'b1;
                km_key = key_of(km_key_id);
            end else if (cyc == late_cyc) begin
                km_key_ack = 1'b1;
                km_key = LATE_KEY;
            end
        end
    end

    // Scoreboard pop on any ack/error pulse.
    task automatic sb_check();
        exp_t e;
        seen_mask = req_key_ack | req_key_error;
        if (seen_mask != '0) begin
            if (sb_q.size() == 0) begin
                flag($sformatf("sb_unexpected ack=%b err=%b", req_key_ack, req_key_error));
            end else begin
                e = sb_q.pop_front();
                sb_pops++;
                chk("sb_ack", 256'(req_key_ack), e.err ? 256'(0) : 256'(4'b0001 << e.who));
                chk("sb_err", 256'(req_key_error), e.err ? 256'(4'b0001 << e.who) : 256'(0));
                chk("sb_key", req_key, e.key);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_check();
        @(posedge clk); #1;
    endtask

    // Wait for the next completion, drop the completed request, wait for IDLE.
    task automatic wait_done(input int limit);
        int p0;
        bit ok;
        p0 = sb_pops;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (sb_pops != p0) ok = 1'b1;
        end
        if (!ok) begin
            flag("wait_resp bound expired");
        end else begin
            req_key_req = req_key_req & ~seen_mask;
            ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                tick();
                if (busy == 1'b0) ok = 1'b1;
            end
            if (!ok) flag("wait_idle bound expired");
        end
    endtask

    task automatic run_vec(input int v);
        exp_t e;
        for (int i = 0; i < NR; i++) begin
            if (vt[v].mask[i] && !req_key_req[i])
                req_key_id[i*32 +: 32] = 32'hA000_0000 | 32'(v << 8) | 32'(i);
        end
        req_key_req = req_key_req | vt[v].mask;
        km_lat = vt[v].lat;
        e.who = vt[v].grant;
        e.err = vt[v].err;
        if (vt[v].err) begin
            e.key = mdl_key;
            mdl_tc++;
        end else begin
            e.key = key_of(req_key_id[vt[v].grant*32 +: 32]);
            mdl_key = e.key;
        end
        sb_q.push_back(e);
        wait_done(40);
        chk($sformatf("vec%0d_tc", v), 256'(timeout_count), 256'(mdl_tc));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        exp_t e;
        int p0, hi, pop_at, exp_tc;
        int rr[NR];
        bit ok;

        // grants derived by hand from round-robin order (last_grant=2 on entry)
        vt[0] = '{4'b0001, 1, 0, 1'b0};
        vt[1] = '{4'b1111, 2, 1, 1'b0};
        vt[2] = '{4'b0000, 1, 2, 1'b0};
        vt[3] = '{4'b0000, 0, 3, 1'b1};
        vt[4] = '{4'b0010, 8, 0, 1'b0};
        vt[5] = '{4'b0000, 3, 1, 1'b0};
        vt[6] = '{4'b1000, 1, 3, 1'b0};
        vt[7] = '{4'b0101, 0, 0, 1'b1};
        vt[8] = '{4'b0000, 5, 2, 1'b0};

        rst = 1'b1;
        req_key_req = '0;
        req_key_id = '0;
        req1 = '0;
        id1 = '0;
        kmack1 = 1'b0;
        kmkey1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 256'(req_key_ack), 256'(0));
        chk("rst_err", 256'(req_key_error), 256'(0));
        chk("rst_key", req_key, 256'(0));
        chk("rst_kmreq", 256'(km_key_req), 256'(0));
        chk("rst_kmid", 256'(km_key_id), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_tc", 256'(timeout_count), 256'(0));
        chk("rst_tc1", 256'(tc1), 256'(0));
        rst = 1'b0;

        // Single request, keymem acks on cycle 3
        req_key_id[2*32 +: 32] = 32'h0000_00A5;
        req_key_req[2] = 1'b1;
        km_lat = 3;
        e.who = 2; e.err = 1'b0; e.key = key_of(32'h0000_00A5);
        mdl_key = e.key;
        sb_q.push_back(e);
        tick();
        chk("s1_kmreq_c1", 256'(km_key_req), 256'(1));
        chk("s1_kmid_c1", 256'(km_key_id), 256'(32'hA5));
        tick(); tick(); tick();
        chk("s1_ack_c4", 256'(req_key_ack), 256'(4'b0100));
        chk("s1_err_c4", 256'(req_key_error), 256'(0));
        chk("s1_key_c4", req_key, key_of(32'h0000_00A5));
        wait_done(10);

        for (int v = 0; v < 9; v++) run_vec(v);

        // Timeout: count km_key_req cycles and locate the error pulse
        req_key_id[1*32 +: 32] = 32'h0000_0B0B;
        km_lat = 0;
        req_key_req[1] = 1'b1;
        e.who = 1; e.err = 1'b1; e.key = mdl_key;
        sb_q.push_back(e);
        mdl_tc++;
        p0 = sb_pops; hi = 0; pop_at = -1;
        for (int n = 1; n <= 30 && pop_at < 0; n++) begin
            tick();
            if (km_key_req) hi++;
            if (sb_pops != p0) pop_at = n;
        end
        chk("to_kmreq_cycles", 256'(hi), 256'(TO));
        chk("to_err_tick", 256'(pop_at), 256'(TO + 2));
        req_key_req[1] = 1'b0;
        repeat (3) tick();
        chk("to_tc", 256'(timeout_count), 256'(mdl_tc));
        chk("to_busy", 256'(busy), 256'(0));

        // Late ack after the timeout is ignored
        late_cyc = cyc + 3;
        repeat (8) tick();
        chk("late_key", req_key, mdl_key);
        chk("late_busy", 256'(busy), 256'(0));
        chk("late_tc", 256'(timeout_count), 256'(mdl_tc));

        // Requester 1 drops during REQ
        req_key_id[1*32 +: 32] = 32'h0000_0C0C;
        km_lat = 3;
        req_key_req[1] = 1'b1;
        e.who = 1; e.err = 1'b0; e.key = key_of(32'h0000_0C0C);
        mdl_key = e.key;
        sb_q.push_back(e);
        p0 = sb_pops;
        tick(); tick();
        req_key_req[1] = 1'b0;
        tick(); tick();
        chk("ab_ack_c4", 256'(req_key_ack), 256'(4'b0010));
        tick();
        chk("ab_busy_c5", 256'(busy), 256'(1));
        tick();
        chk("ab_busy_c6", 256'(busy), 256'(0));
        chk("ab_pops", 256'(sb_pops - p0), 256'(1));

        // Reset pulsed during REQ
        req_key_id[3*32 +: 32] = 32'h0000_0D0D;
        km_lat = 0;
        req_key_req[3] = 1'b1;
        tick(); tick(); tick();
        chk("rm_kmreq_before", 256'(km_key_req), 256'(1));
        rst = 1'b1;
        #1;
        chk("rm_ack", 256'(req_key_ack), 256'(0));
        chk("rm_err", 256'(req_key_error), 256'(0));
        chk("rm_key", req_key, 256'(0));
        chk("rm_kmreq", 256'(km_key_req), 256'(0));
        chk("rm_kmid", 256'(km_key_id), 256'(0));
        chk("rm_busy", 256'(busy), 256'(0));
        chk("rm_tc", 256'(timeout_count), 256'(0));
        tick(); tick();
        rst = 1'b0;
        mdl_tc = 0;
        req_key_id[0*32 +: 32] = 32'h0000_0E0E;
        req_key_req[0] = 1'b1;
        km_lat = 1;
        e.who = 0; e.err = 1'b0; e.key = key_of(32'h0000_0E0E);
        sb_q.push_back(e);
        e.who = 3; e.err = 1'b0; e.key = key_of(32'h0000_0D0D);
        sb_q.push_back(e);
        mdl_key = e.key;
        wait_done(40);
        wait_done(40);

        // Fairness: all four requesters, re-raise 2 cycles after drop
        for (int i = 0; i < NR; i++) begin
            req_key_id[i*32 +: 32] = 32'hF000_0000 | 32'(i);
            rr[i] = -1;
        end
        for (int k = 0; k < 40; k++) begin
            e.who = k % NR; e.err = 1'b0; e.key = key_of(32'hF000_0000 | 32'(k % NR));
            sb_q.push_back(e);
        end
        km_lat = 1;
        req_key_req = '1;
        p0 = sb_pops;
        for (int c = 0; c < 600 && (sb_pops - p0) < 40; c++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (rr[i] == c) req_key_req[i] = 1'b1;
                if (seen_mask[i]) begin
                    req_key_req[i] = 1'b0;
                    rr[i] = c + 2;
                end
            end
        end
        req_key_req = '0;
        chk("rr_grants", 256'(sb_pops - p0), 256'(40));
        repeat (4) tick();
        chk("rr_idle", 256'(busy), 256'(0));
        chk("rr_sb_empty", 256'(sb_q.size()), 256'(0));

        // NUM_REQ=1, TIMEOUT_CYCLES=1: pass-through; ack in the only REQ cycle wins
        id1 = 32'h0000_1111;
        req1 = 1'b1;
        tick();
        chk("pt_kmreq", 256'(kmreq1), 256'(1));
        chk("pt_kmid", 256'(kmid1), 256'(32'h1111));
        kmack1 = 1'b1;
        kmkey1 = key_of(32'h0000_1111);
        tick();
        chk("pt_ack", 256'(ack1), 256'(1));
        chk("pt_err", 256'(err1), 256'(0));
        chk("pt_key", key1, key_of(32'h0000_1111));
        kmack1 = 1'b0;
        req1 = 1'b0;
        tick(); tick();
        chk("pt_busy", 256'(busy1), 256'(0));

        // one real timeout, then preload the counter near saturation
        req1 = 1'b1;
        tick(); tick();
        chk("sat_err_first", 256'(err1), 256'(1));
        chk("sat_tc_first", 256'(tc1), 256'(1));
        req1 = 1'b0;
        tick(); tick();
        force dut1.timeout_count = 16'hFFFC;
        tick();
        release dut1.timeout_count;
        exp_tc = 32'hFFFC;
        for (int k = 0; k < 4; k++) begin
            req1 = 1'b1;
            tick(); tick();
            if (exp_tc < 32'hFFFF) exp_tc++;
            chk($sformatf("sat_err%0d", k), 256'(err1), 256'(1));
            chk($sformatf("sat_tc%0d", k), 256'(tc1), 256'(exp_tc));
            chk($sformatf("sat_key%0d", k), key1, key_of(32'h0000_1111));
            req1 = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 6 && !ok; i++) begin
                tick();
                if (busy1 == 1'b0) ok = 1'b1;
            end
            if (!ok) flag("sat_idle bound expired");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
